// File: rtl/demux_pkg.sv
// Shared definitions for the demux_dist lane distributor: lane state encoding,
// drop counter width and the select-width helper.
package demux_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    // Ceiling log2, clamped to 1 so a select port always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One output slot of demux_dist: holds a single word until its consumer takes it.
module demux_lane
    import demux_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [BIT_WIDTH-1:0] data_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [BIT_WIDTH-1:0] data_o
);

    lane_state_e          state_q, state_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LANE_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load wins over a drain: simultaneous take and refill keeps the slot full.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = LANE_FULL;
            data_d  = data_i;
        end else if (ready_i) begin
            state_d = LANE_EMPTY;
        end
    end

    assign valid_o = (state_q == LANE_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux_dist.sv
// Registered 1-to-DEPTH demultiplexer with per-lane valid/ready slots.
// Optional DEMUX_DROP_CNT_EN adds a saturating count of out-of-range discards.
module demux_dist
    import demux_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [BIT_WIDTH-1:0]       dataIn,
    input  logic [SEL_WIDTH-1:0]       select,
    output logic [DEPTH-1:0]           outValid,
    input  logic [DEPTH-1:0]           outReady,
    output logic [BIT_WIDTH*DEPTH-1:0] dataOut,
    output logic                       dropErr
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]      dropCount
`endif
);

    logic             in_range;
    logic             accept;
    logic             drop_d;
    logic             drop_err_q;
    logic [DEPTH-1:0] lane_hit;
    logic [DEPTH-1:0] lane_take;

    assign in_range = ({1'b0, select} < (SEL_WIDTH + 1)'(DEPTH));

    // Out-of-range selects are always accepted so a stray index cannot stall the producer.
    assign inReady = !in_range || (|lane_take);
    assign accept  = inValid && inReady;
    assign drop_d  = inValid && !in_range;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_lane
            assign lane_hit[gi]  = in_range && (select == SEL_WIDTH'(gi));
            assign lane_take[gi] = lane_hit[gi] && (!outValid[gi] || outReady[gi]);

            demux_lane #(
                .BIT_WIDTH(BIT_WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .load_i  (accept && lane_hit[gi]),
                .data_i  (dataIn),
                .ready_i (outReady[gi]),
                .valid_o (outValid[gi]),
                .data_o  (dataOut[BIT_WIDTH*gi +: BIT_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= drop_d;
        end
    end

    assign dropErr = drop_err_q;

`ifdef DEMUX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_dist.sv
// Directed bench for demux_dist: an 8-lane instance and a 5-lane instance
// exercising handshakes, streaming, out-of-range discards and async reset.
module tb_demux_dist;

    logic        clk;
    logic        rst;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_data_in;
    logic [2:0]  a_select;
    logic [7:0]  a_out_valid;
    logic [7:0]  a_out_ready;
    logic [63:0] a_data_out;
    logic        a_drop_err;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_data_in;
    logic [2:0]  b_select;
    logic [4:0]  b_out_valid;
    logic [4:0]  b_out_ready;
    logic [39:0] b_data_out;
    logic        b_drop_err;

`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] a_drop_count;
    logic [15:0] b_drop_count;
`endif

    int errors;
    int checks;

    demux_dist #(.BIT_WIDTH(8), .DEPTH(8)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .inValid  (a_in_valid),
        .inReady  (a_in_ready),
        .dataIn   (a_data_in),
        .select   (a_select),
        .outValid (a_out_valid),
        .outReady (a_out_ready),
        .dataOut  (a_data_out),
        .dropErr  (a_drop_err)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .dropCount(a_drop_count)
`endif
    );

    demux_dist #(.BIT_WIDTH(8), .DEPTH(5)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .inValid  (b_in_valid),
        .inReady  (b_in_ready),
        .dataIn   (b_data_in),
        .select   (b_select),
        .outValid (b_out_valid),
        .outReady (b_out_ready),
        .dataOut  (b_data_out),
        .dropErr  (b_drop_err)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .dropCount(b_drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane_a(input logic [63:0] bus, input int idx);
        return bus[idx*8 +: 8];
    endfunction

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_data_in   = 8'h00;
        a_select    = 3'd0;
        a_out_ready = 8'h00;
        b_in_valid  = 1'b0;
        b_data_in   = 8'h00;
        b_select    = 3'd0;
        b_out_ready = 5'h00;
        #3;

        // Reset state
        check("rst_out_valid", 64'(a_out_valid), 64'h0);
        check("rst_data_out", a_data_out, 64'h0);
        check("rst_drop_err", 64'(a_drop_err), 64'h0);
        check("rst_in_ready_sel0", 64'(a_in_ready), 64'h1);
        a_select = 3'd5;
        #1;
        check("rst_in_ready_sel5", 64'(a_in_ready), 64'h1);
`ifdef DEMUX_DROP_CNT_EN
        check("rst_drop_count", 64'(b_drop_count), 64'h0);
`endif
        tick();
        rst = 1'b0;

        // Single word to lane 3 with no consumer
        a_in_valid = 1'b1;
        a_data_in  = 8'hA5;
        a_select   = 3'd3;
        #1;
        check("a5_in_ready", 64'(a_in_ready), 64'h1);
        tick();
        check("a5_out_valid", 64'(a_out_valid), 64'h08);
        check("a5_lane3", 64'(lane_a(a_data_out, 3)), 64'hA5);

        // Second word to the full lane is refused
        a_data_in = 8'h77;
        #1;
        check("full_in_ready", 64'(a_in_ready), 64'h0);
        tick();
        check("full_lane3_held", 64'(lane_a(a_data_out, 3)), 64'hA5);
        check("full_out_valid", 64'(a_out_valid), 64'h08);

        // Replace while the consumer takes the old word
        a_out_ready = 8'h08;
        a_data_in   = 8'h5A;
        #1;
        check("repl_in_ready", 64'(a_in_ready), 64'h1);
        tick();
        check("repl_lane3", 64'(lane_a(a_data_out, 3)), 64'h5A);
        check("repl_out_valid", 64'(a_out_valid), 64'h08);
        a_in_valid = 1'b0;
        tick();
        check("drain_out_valid", 64'(a_out_valid), 64'h00);
        check("drain_lane3_kept", 64'(lane_a(a_data_out, 3)), 64'h5A);

        // Round-robin streaming with all consumers ready
        a_out_ready = 8'hFF;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_select  = 3'(i % 8);
            a_data_in = 8'(i);
            #1;
            check($sformatf("stream_in_ready_%0d", i), 64'(a_in_ready), 64'h1);
            tick();
            check($sformatf("stream_lane%0d_w%0d", i % 8, i), 64'(lane_a(a_data_out, i % 8)), 64'(i));
            check($sformatf("stream_valid_%0d", i), 64'(a_out_valid[i % 8]), 64'h1);
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_final_data", a_data_out, 64'h0F0E0D0C0B0A0908);
        check("stream_final_valid", 64'(a_out_valid), 64'h00);

        // Drain one lane while loading another in the same cycle
        a_out_ready = 8'h00;
        a_in_valid  = 1'b1;
        a_select    = 3'd2;
        a_data_in   = 8'h22;
        tick();
        a_out_ready = 8'h04;
        a_select    = 3'd4;
        a_data_in   = 8'h44;
        tick();
        check("conc_out_valid", 64'(a_out_valid), 64'h10);
        check("conc_lane4", 64'(lane_a(a_data_out, 4)), 64'h44);
        a_out_ready = 8'h10;
        a_in_valid  = 1'b0;
        tick();
        a_out_ready = 8'h00;

        // Fill lanes 1 and 6, then reset asynchronously mid-cycle
        a_in_valid = 1'b1;
        a_select   = 3'd1;
        a_data_in  = 8'h11;
        tick();
        a_select  = 3'd6;
        a_data_in = 8'h66;
        tick();
        check("prerst_out_valid", 64'(a_out_valid), 64'h42);
        a_select  = 3'd1;
        a_data_in = 8'hEE;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(a_out_valid), 64'h00);
        check("async_rst_data_out", a_data_out, 64'h0);
        tick();
        check("rst_no_accept_valid", 64'(a_out_valid), 64'h00);
        check("rst_no_accept_data", a_data_out, 64'h0);
        rst        = 1'b0;
        a_in_valid = 1'b0;
        tick();
        check("a_drop_err_idle", 64'(a_drop_err), 64'h0);

        // Five-lane instance: out-of-range select is discarded
        b_in_valid = 1'b1;
        b_select   = 3'd0;
        b_data_in  = 8'h12;
        tick();
        check("b_fill_valid", 64'(b_out_valid), 64'h01);
        b_select  = 3'd6;
        b_data_in = 8'hFF;
        #1;
        check("b_drop_in_ready", 64'(b_in_ready), 64'h1);
        tick();
        check("b_drop_err_pulse", 64'(b_drop_err), 64'h1);
        check("b_drop_valid_same", 64'(b_out_valid), 64'h01);
        check("b_drop_data_same", 64'(b_data_out), 64'h0000000012);
`ifdef DEMUX_DROP_CNT_EN
        check("b_drop_count_1", 64'(b_drop_count), 64'h1);
`endif
        b_in_valid = 1'b0;
        tick();
        check("b_drop_err_clear", 64'(b_drop_err), 64'h0);
        b_in_valid = 1'b1;
        b_select   = 3'd5;
        b_data_in  = 8'h55;
        #1;
        check("b_sel5_in_ready", 64'(b_in_ready), 64'h1);
        tick();
        check("b_sel5_drop_err", 64'(b_drop_err), 64'h1);
        check("b_sel5_valid_same", 64'(b_out_valid), 64'h01);
`ifdef DEMUX_DROP_CNT_EN
        check("b_drop_count_2", 64'(b_drop_count), 64'h2);
        b_select = 3'd7;
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        check("b_drop_count_sat", 64'(b_drop_count), 64'hFFFF);
        tick();
        check("b_drop_count_hold", 64'(b_drop_count), 64'hFFFF);
`endif
        b_in_valid = 1'b0;
        tick();
        check("b_drop_err_end", 64'(b_drop_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
